bi_test_controller: RTL and testbench
=====================================

# bi_test_controller

Sequencing controller that sits directly upstream of the bus-invert `DataPath` and drives its stage enables. It also consumes `DataPath`'s `isequal` result.
- One run: clear the datapath, stream `NUM_WORDS` LFSR words through generator → encoder → bus → decoder → comparator with staggered per-stage enables, drain the pipeline, then pulse `done` so the transition counter latches its histogram.
- It accumulates mismatch statistics and reports pass/fail; it is the on-chip test sequencer for the FPGA power-measurement build.

## Interface
- `NUM_WORDS`, 2000, words streamed per run (≥1).
- `CNT_W`, 11, width of word index and error counters.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, level-sampled.
- `isequal` in 1: `DataPath` comparator result.
- `dp_rst_n` out 1: active-low reset to `DataPath`.
- `en_gen_data` out 1: `DataPath` stage enable.
- `en_enc` out 1: `DataPath` stage enable.
- `en_bus` out 1: `DataPath` stage enable.
- `en_trans_count` out 1: `DataPath` stage enable.
- `en_dec` out 1: `DataPath` stage enable.
- `en_k_comp` out 1: `DataPath` stage enable.
- `done` out 1: one-cycle latch strobe to `DataPath`.
- `busy` out 1: high from CLEAR through REPORT.
- `pass` out 1: run finished with zero mismatches.
- `err_count` out CNT_W: mismatching words, saturating.
- `first_err_idx` out CNT_W: 0-based index of first mismatching word; all-ones if none.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, REPORT, FINISH. All outputs are registered.
- **IDLE/FINISH**
  - `start`=1 → CLEAR.
  - Entering CLEAR zeroes `err_count`, `pass` and the word counters, and sets `first_err_idx` to all-ones.
  - FINISH holds the results until the next `start`.
- **CLEAR**: exactly 2 cycles with `dp_rst_n`=0 and all enables 0, so the transition histogram starts from zero. Then → RUN.
- **RUN**
  - `en_gen_data`=1 for exactly `NUM_WORDS` cycles, counted by `gen_cnt`. Then → DRAIN.
- **Stage enables**: each is `en_gen_data` delayed by a fixed offset, implemented as a shift register:
  - `en_enc` +1
  - `en_bus` +2
  - `en_dec` +3
  - `en_trans_count` +3
  - `en_k_comp` +4
- **Checking**
  - Internal `chk_valid` = `en_k_comp` delayed 1 (offset 5).
  - On each `chk_valid` cycle, `isequal` is sampled and `chk_idx` increments (0..`NUM_WORDS`-1).
  - If `isequal`=0: `err_count` increments, saturating at 2^CNT_W−1.
  - On the first mismatch of the run, `first_err_idx` ← `chk_idx`.
- **DRAIN**: exactly 5 cycles with `en_gen_data`=0 while the delayed enables empty out. Then → REPORT.
- **REPORT**
  - `done`=1 for exactly one cycle. Then → FINISH.
  - On entry to FINISH, `pass` ← (`err_count`==0).
- `busy`=1 in CLEAR, RUN, DRAIN and REPORT.
- `start` is ignored while `busy`=1.
- Holding `start` high in FINISH starts back-to-back runs.

## Timing
- **Reset**: `rst`=1 at a clock edge forces IDLE. After that edge:
  - all enables, `done`, `busy`, `pass` = 0, and `err_count`=0;
  - `first_err_idx` = all-ones;
  - `dp_rst_n`=0 while `rst` is high, and 1 in IDLE afterwards.
- Reset mid-run aborts immediately: no `done` pulse is ever produced for the aborted run.
- Cycle numbering, with `start` sampled high in cycle t:
  - t+1, t+2: CLEAR.
  - t+3 .. t+2+N: `en_gen_data`=1.
  - Last `chk_valid` at t+7+N.
  - `done`=1 at t+8+N.
  - `busy` falls and `pass` is valid at t+9+N.
- Total run length: `NUM_WORDS`+8 cycles from `start` to `done`.
- Enables form contiguous windows of exactly `NUM_WORDS` cycles each, with no gaps.
- Exactly `NUM_WORDS` `chk_valid` cycles occur per run.
- Simultaneous mismatch and saturation: `err_count` stays at its maximum; `first_err_idx` is unaffected after the first mismatch.
- `NUM_WORDS`=1: single-cycle windows; `done` at t+9.

## Test plan
- **Reset values**: assert `rst` for 3 cycles → all outputs at the reset values listed in Timing; `dp_rst_n`=0 during reset and 1 afterwards.
- **Clean run**: `NUM_WORDS`=16, `isequal` tied 1, pulse `start` at cycle 0 →
  - `dp_rst_n` low cycles 1–2;
  - `en_gen_data` high cycles 3–18, `en_k_comp` high cycles 7–22;
  - `done` only at cycle 24;
  - `pass`=1 and `err_count`=0 from cycle 25.
- **Mismatches**: `NUM_WORDS`=16, drive `isequal`=0 on `chk_valid` cycles for words 5 and 9 → `err_count`=2, `first_err_idx`=5, `pass`=0.
- **Saturation**: `CNT_W`=3, `NUM_WORDS`=12, `isequal`=0 throughout → `err_count`=7, `first_err_idx`=0.
- **Ignored start / back-to-back**
  - `start` pulsed again during RUN → no effect, `done` still at cycle 24.
  - `start` held high from cycle 0 → second CLEAR begins at cycle 26, and `err_count` is cleared at its entry.
- **Reset mid-run**: `rst` asserted at cycle 10 of a 16-word run → all enables 0 after that edge, no `done` pulse, state IDLE; a new `start` then produces a full clean run.

Source files
------------

// File: rtl/bi_test_controller.sv
// bi_test_controller: sequences one bus-invert DataPath test run and tallies comparator mismatches.
module bi_test_controller #(
    parameter int NUM_WORDS = 2000,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isequal,
    output logic             dp_rst_n,
    output logic             en_gen_data,
    output logic             en_enc,
    output logic             en_bus,
    output logic             en_trans_count,
    output logic             en_dec,
    output logic             en_k_comp,
    output logic             done,
    output logic             busy,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);
    // word counters are sized by NUM_WORDS so they still count a full run when CNT_W is narrow
    localparam int WC = $clog2(NUM_WORDS + 1);
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, RUN = 3'd2, DRAIN = 3'd3, REPORT = 3'd4, FINISH = 3'd5;
    logic [2:0]    state, nxt;
    logic          clr_cnt;
    logic [WC-1:0] gen_cnt, chk_idx;
    logic [2:0]    drain_cnt;
    logic [4:0]    sr;
    assign en_enc         = sr[0];
    assign en_bus         = sr[1];
    assign en_dec         = sr[2];
    assign en_trans_count = sr[2];
    assign en_k_comp      = sr[3];
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE, FINISH: nxt = start ? CLEAR : state;
            CLEAR:        nxt = clr_cnt ? RUN : CLEAR;
            RUN:          nxt = (gen_cnt == WC'(NUM_WORDS - 1)) ? DRAIN : RUN;
            DRAIN:        nxt = (drain_cnt == 3'd4) ? REPORT : DRAIN;
            REPORT:       nxt = FINISH;
            default:      nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clr_cnt       <= 1'b0;
            gen_cnt       <= '0;
            chk_idx       <= '0;
            drain_cnt     <= '0;
            sr            <= '0;
            en_gen_data   <= 1'b0;
            dp_rst_n      <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else begin
            state       <= nxt;
            clr_cnt     <= (state == CLEAR) ? !clr_cnt : 1'b0;
            gen_cnt     <= (state == RUN) ? gen_cnt + WC'(1) : '0;
            drain_cnt   <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            en_gen_data <= nxt == RUN;
            sr          <= {sr[3:0], en_gen_data};
            dp_rst_n    <= nxt != CLEAR;
            done        <= nxt == REPORT;
            busy        <= nxt == CLEAR || nxt == RUN || nxt == DRAIN || nxt == REPORT;
            if (nxt == CLEAR && state != CLEAR) begin
                err_count     <= '0;
                pass          <= 1'b0;
                first_err_idx <= '1;
                chk_idx       <= '0;
            end else if (sr[4]) begin
                chk_idx <= chk_idx + WC'(1);
                // err_count only leaves zero on a mismatch, so zero marks the run's first one
                if (!isequal) begin
                    if (err_count != '1)
                        err_count <= err_count + CNT_W'(1);
                    if (err_count == '0)
                        first_err_idx <= CNT_W'(chk_idx);
                end
            end
            if (state == REPORT)
                pass <= err_count == '0;
        end
    end
endmodule

// File: tb/tb_bi_test_controller.sv
// tb_bi_test_controller: randomized runs checked cycle-by-cycle against a timing/result model.
module tb_bi_test_controller;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int checks = 0, failures = 0;

    logic start_m = 1'b0, iseq_m = 1'b1;
    logic dp_m, gen_m, enc_m, bus_m, tc_m, dec_m, kc_m, done_m, busy_m, pass_m;
    logic [10:0] err_m, fe_m;
    logic start_s = 1'b0, iseq_s = 1'b0;
    logic dp_s, gen_s, enc_s, bus_s, tc_s, dec_s, kc_s, done_s, busy_s, pass_s;
    logic [2:0] err_s, fe_s;
    logic start_o = 1'b0, iseq_o = 1'b1;
    logic dp_o, gen_o, enc_o, bus_o, tc_o, dec_o, kc_o, done_o, busy_o, pass_o;
    logic [3:0] err_o, fe_o;

    bi_test_controller #(.NUM_WORDS(16), .CNT_W(11)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .isequal(iseq_m), .dp_rst_n(dp_m),
        .en_gen_data(gen_m), .en_enc(enc_m), .en_bus(bus_m), .en_trans_count(tc_m),
        .en_dec(dec_m), .en_k_comp(kc_m), .done(done_m), .busy(busy_m), .pass(pass_m),
        .err_count(err_m), .first_err_idx(fe_m));
    bi_test_controller #(.NUM_WORDS(12), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .isequal(iseq_s), .dp_rst_n(dp_s),
        .en_gen_data(gen_s), .en_enc(enc_s), .en_bus(bus_s), .en_trans_count(tc_s),
        .en_dec(dec_s), .en_k_comp(kc_s), .done(done_s), .busy(busy_s), .pass(pass_s),
        .err_count(err_s), .first_err_idx(fe_s));
    bi_test_controller #(.NUM_WORDS(1), .CNT_W(4)) dut_o (
        .clk(clk), .rst(rst), .start(start_o), .isequal(iseq_o), .dp_rst_n(dp_o),
        .en_gen_data(gen_o), .en_enc(enc_o), .en_bus(bus_o), .en_trans_count(tc_o),
        .en_dec(dec_o), .en_k_comp(kc_o), .done(done_o), .busy(busy_o), .pass(pass_o),
        .err_count(err_o), .first_err_idx(fe_o));

    wire [8:0] ctl_m = {dp_m, gen_m, enc_m, bus_m, dec_m, tc_m, kc_m, done_m, busy_m};
    wire [8:0] ctl_s = {dp_s, gen_s, enc_s, bus_s, dec_s, tc_s, kc_s, done_s, busy_s};
    wire [8:0] ctl_o = {dp_o, gen_o, enc_o, bus_o, dec_o, tc_o, kc_o, done_o, busy_o};

    // cycle c relative to the cycle in which start was sampled; n = words per run
    function automatic logic [8:0] exp_ctl(input int c, input int n);
        logic [8:0] v;
        v[8] = !(c == 1 || c == 2);
        v[7] = c >= 3 && c <= 2 + n;
        v[6] = c >= 4 && c <= 3 + n;
        v[5] = c >= 5 && c <= 4 + n;
        v[4] = c >= 6 && c <= 5 + n;
        v[3] = c >= 6 && c <= 5 + n;
        v[2] = c >= 7 && c <= 6 + n;
        v[1] = c == n + 8;
        v[0] = c >= 1 && c <= n + 8;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ctl_m, ctl_s, ctl_o} !== 27'd0) begin
                failures++;
                $display("FAIL reset_ctl cyc=%0d got=%h/%h/%h exp=0", i, ctl_m, ctl_s, ctl_o);
            end
            checks++;
            if ({err_m, fe_m, pass_m, err_s, fe_s, pass_s, err_o, fe_o, pass_o} !== {11'd0, 11'h7ff, 1'b0, 3'd0, 3'h7, 1'b0, 4'd0, 4'hf, 1'b0}) begin
                failures++;
                $display("FAIL reset_res got=%h,%h,%b %h,%h,%b %h,%h,%b", err_m, fe_m, pass_m, err_s, fe_s, pass_s, err_o, fe_o, pass_o);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ctl_m, ctl_s, ctl_o} !== {3{9'b1_0000_0000}}) begin
            failures++;
            $display("FAIL reset_release got=%h/%h/%h exp=100", ctl_m, ctl_s, ctl_o);
        end
    endtask

    task automatic run_main(input string name, input logic [15:0] mask, input bit extra_start, input bit hold);
        int e = 0, f = -1, xc = $urandom_range(3, 18), ncyc = hold ? 30 : 27;
        logic [10:0] efe;
        logic [8:0] ev;
        for (int i = 0; i < 16; i++)
            if (mask[i]) begin
                e++;
                if (f < 0) f = i;
            end
        efe = (f < 0) ? 11'h7ff : 11'(f);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            ev = (hold && c >= 26) ? exp_ctl(c - 25, 16) : exp_ctl(c, 16);
            checks++;
            if (ctl_m !== ev) begin
                failures++;
                $display("FAIL %s_ctl c=%0d got=%b exp=%b", name, c, ctl_m, ev);
            end
            if (c == 25 || (c == 26 && !hold)) begin
                checks++;
                if ({err_m, fe_m, pass_m} !== {11'(e), efe, e == 0}) begin
                    failures++;
                    $display("FAIL %s_res c=%0d got=%0d,%0d,%b exp=%0d,%0d,%b", name, c, err_m, fe_m, pass_m, e, efe, e == 0);
                end
            end
            if (hold && c == 26) begin
                checks++;
                if ({err_m, fe_m, pass_m} !== {11'd0, 11'h7ff, 1'b0}) begin
                    failures++;
                    $display("FAIL %s_reclear got=%0d,%0d,%b exp=0,2047,0", name, err_m, fe_m, pass_m);
                end
            end
            start_m = hold || c == 0 || (extra_start && c == xc);
            iseq_m = (c >= 8 && c < 24) ? !mask[c - 8] : 1'($urandom);
        end
        start_m = 1'b0;
    endtask

    task automatic test_clean();
        run_main("clean", 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_mismatch();
        run_main("mism", 16'h0220, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            run_main("rand", 16'($urandom & $urandom), 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_main("ignstart", 16'($urandom & $urandom), 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_main("b2b", 16'h8001 | 16'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            if (c <= 10) begin
                checks++;
                if (ctl_m !== exp_ctl(c, 16)) begin
                    failures++;
                    $display("FAIL midrst_pre c=%0d got=%b exp=%b", c, ctl_m, exp_ctl(c, 16));
                end
            end else if (c == 11) begin
                checks++;
                if ({ctl_m, err_m, fe_m} !== {9'd0, 11'd0, 11'h7ff}) begin
                    failures++;
                    $display("FAIL midrst_abort got=%b,%0d,%0d exp=0,0,2047", ctl_m, err_m, fe_m);
                end
            end else begin
                checks++;
                if (ctl_m !== 9'b1_0000_0000) begin
                    failures++;
                    $display("FAIL midrst_idle c=%0d got=%b exp=100000000", c, ctl_m);
                end
            end
            start_m = c == 0;
            rst = c == 10;
            iseq_m = 1'($urandom);
        end
        run_main("postrst", 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if (ctl_s !== exp_ctl(c, 12)) begin
                failures++;
                $display("FAIL sat_ctl c=%0d got=%b exp=%b", c, ctl_s, exp_ctl(c, 12));
            end
            if (c == 21) begin
                checks++;
                if ({err_s, fe_s, pass_s} !== {3'd7, 3'd0, 1'b0}) begin
                    failures++;
                    $display("FAIL sat_res got=%0d,%0d,%b exp=7,0,0", err_s, fe_s, pass_s);
                end
            end
            start_s = c == 0;
            iseq_s = 1'b0;
        end
    endtask

    task automatic test_one_word();
        for (int r = 0; r < 2; r++) begin
            logic ok = (r == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                checks++;
                if (ctl_o !== exp_ctl(c, 1)) begin
                    failures++;
                    $display("FAIL one_ctl c=%0d got=%b exp=%b", c, ctl_o, exp_ctl(c, 1));
                end
                if (c == 10) begin
                    checks++;
                    if ({err_o, fe_o, pass_o} !== {4'(!ok), ok ? 4'hf : 4'h0, ok}) begin
                        failures++;
                        $display("FAIL one_res got=%0d,%0d,%b exp=%0d,%0d,%b", err_o, fe_o, pass_o, !ok, ok ? 15 : 0, ok);
                    end
                end
                start_o = c == 0;
                iseq_o = (c == 8) ? ok : 1'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_mismatch();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_saturation();
        test_one_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
